// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one data-memory port between the CPU LSU (port 0) and the debug/DMA loader (port 1).
// Optional watchdog: define DMEM_ARB_TIMEOUT_EN to complete a hung access with pN_err after TIMEOUT_CYCLES.
module dmem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [3:0]        p0_mask,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [3:0]        p1_mask,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_mask,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_stall
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_START, S_WAIT_END} state_t;

    if (TIMEOUT_CYCLES < 4) begin : g_bad_timeout
        $error("dmem_arbiter: TIMEOUT_CYCLES must be >= 4");
    end

    state_t                   state_q, state_d;
    logic                     grant_q, grant_d;
    logic                     last_grant_q, last_grant_d;
    logic                     we_q, we_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [DATA_W-1:0]        wdata_q, wdata_d;
    logic [3:0]               mask_q, mask_d;
    logic [1:0]               done_q, done_d;
    logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]               err_q, err_d;
    logic                     pick;
    logic                     finish;
    logic                     timed_out;

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        done_d       = '0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        pick         = 1'b0;
        finish       = 1'b0;
        timed_out    = 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A stall seen here belongs to an access we no longer own (e.g. reset mid-access).
                if (!mem_stall && (p0_req || p1_req)) begin
                    pick         = p1_req && (!p0_req || !last_grant_q);
                    grant_d      = pick;
                    last_grant_d = pick;
                    we_d         = pick ? p1_we    : p0_we;
                    addr_d       = pick ? p1_addr  : p0_addr;
                    wdata_d      = pick ? p1_wdata : p0_wdata;
                    mask_d       = pick ? p1_mask  : p0_mask;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_START;
`ifdef DMEM_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT_START: if (mem_stall) state_d = S_WAIT_END;
            S_WAIT_END:   if (!mem_stall) finish = 1'b1;
            default:      state_d = S_IDLE;
        endcase
`ifdef DMEM_ARB_TIMEOUT_EN
        if ((state_q == S_WAIT_START || state_q == S_WAIT_END) && !finish) begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == TO_LAST) begin
                finish    = 1'b1;
                timed_out = 1'b1;
            end
        end
`endif
        if (finish) begin
            state_d           = S_IDLE;
            done_d[grant_q]   = 1'b1;
            rdata_d[grant_q]  = (we_q || timed_out) ? '0 : mem_rdata;
            err_d[grant_q]    = timed_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            done_q       <= '0;
            rdata_q      <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

`ifdef DMEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    // Command strobes decode straight from the state flop so they last exactly the ISSUE cycle.
    assign mem_read  = (state_q == S_ISSUE) && !we_q;
    assign mem_write = (state_q == S_ISSUE) &&  we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_mask  = mask_q;

    assign p0_done  = done_q[0];
    assign p1_done  = done_q[1];
    assign p0_rdata = rdata_q[0];
    assign p1_rdata = rdata_q[1];
    assign p0_err   = err_q[0];
    assign p1_err   = err_q[1];

endmodule
